// File: rtl/shift_sequencer_pkg.sv
// shift_pkg: shared encodings for the shift sequencer and its bench
package shift_pkg;
    localparam int SEQ_W     = 8;
    localparam int SEQ_AMT_W = 3;

    typedef enum logic [1:0] {
        SHM_LOGIC = 2'b00,
        SHM_ARITH = 2'b01,
        SHM_ROT   = 2'b10,
        SHM_RSVD  = 2'b11
    } shmode_e;

    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_SHR  = 2'b01,
        SR_SHL  = 2'b10,
        SR_LOAD = 2'b11
    } sr_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_e;
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: command bus plus shift-register control/feedback pins
interface shift_sequencer_if;
    import shift_pkg::*;
    logic                 start;
    logic [SEQ_W-1:0]     din;
    logic [SEQ_AMT_W-1:0] amt;
    logic                 dir;
    logic [1:0]           mode;
    logic                 busy;
    logic                 done;
    logic [SEQ_W-1:0]     result;
    logic [SEQ_W-1:0]     sr_in;
    logic                 sr_c1;
    logic                 sr_c0;
    logic                 sr_enb;
    logic                 sr_sli;
    logic                 sr_sri;
    logic [SEQ_W-1:0]     sr_out;

    modport slave (
        input  start, din, amt, dir, mode, sr_out,
        output busy, done, result, sr_in, sr_c1, sr_c0, sr_enb, sr_sli, sr_sri
    );
    modport master (
        output start, din, amt, dir, mode, sr_out,
        input  busy, done, result, sr_in, sr_c1, sr_c0, sr_enb, sr_sli, sr_sri
    );
endinterface

// File: rtl/eight_bit_UniversalShiftRegister.sv
// eight_bit_UniversalShiftRegister: 8-bit hold/shift-right/shift-left/load register
module eight_bit_UniversalShiftRegister (
    input  logic       clk,
    input  logic       enb,
    input  logic       c1,
    input  logic       c0,
    input  logic       sli,
    input  logic       sri,
    input  logic [7:0] pin,
    output logic [7:0] q
);
    logic [7:0] q_d;

    always_comb
        q_d = !enb            ? q :
              ({c1, c0} == 2'b01) ? {sri, q[7:1]} :
              ({c1, c0} == 2'b10) ? {q[6:0], sli} :
              ({c1, c0} == 2'b11) ? pin : q;

    always_ff @(posedge clk)
        q <= q_d;
endmodule

// File: rtl/shift_sequencer_counter.sv
// shift_seq_counter: loadable down-counter with zero and one flags
module shift_seq_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] d_i,
    output logic         zero_o,
    output logic         one_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb
        cnt_d = load_i ? d_i : dec_i ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == W'(1));
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-bit shift/rotate by sequencing an external universal shift register.
// SHIFT_SEQ_ROTATE_EN enables mode 10 rotate; otherwise mode 10 behaves as logical.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_sequencer_if.slave bus
);
    state_e           state_q;
    sr_sel_e          sel_q;
    shmode_e          mode_q;
    logic [AMT_W-1:0] amt_q;
    logic [WIDTH-1:0] sr_in_q, result_q;
    logic             dir_q, enb_q, busy_q, done_q;
    logic             cnt_zero, cnt_one, rot, shifting;

    shift_seq_counter #(.W(AMT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == LOAD),
        .dec_i  (state_q == SHIFT),
        .d_i    (amt_q),
        .zero_o (cnt_zero),
        .one_o  (cnt_one)
    );

    // Control pins are registered, so each is set on the edge entering its state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= SR_HOLD;
            mode_q   <= SHM_LOGIC;
            amt_q    <= '0;
            dir_q    <= 1'b0;
            sr_in_q  <= '0;
            result_q <= '0;
            enb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= LOAD;
                    amt_q   <= bus.amt;
                    dir_q   <= bus.dir;
                    mode_q  <= shmode_e'(bus.mode);
                    sr_in_q <= bus.din;
                    sel_q   <= SR_LOAD;
                    enb_q   <= 1'b1;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    state_q <= (amt_q == '0) ? DONE : SHIFT;
                    sel_q   <= (amt_q == '0) ? SR_HOLD : (dir_q ? SR_SHR : SR_SHL);
                    enb_q   <= (amt_q != '0);
                    done_q  <= (amt_q == '0);
                end
                SHIFT: if (cnt_one || cnt_zero) begin
                    state_q <= DONE;
                    sel_q   <= SR_HOLD;
                    enb_q   <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    result_q <= bus.sr_out;
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_ROTATE_EN
    assign rot = (mode_q == SHM_ROT);
`else
    assign rot = 1'b0;
`endif

    assign shifting   = (state_q == SHIFT);
    assign bus.sr_sli = shifting && !dir_q && rot && bus.sr_out[WIDTH-1];
    assign bus.sr_sri = shifting && dir_q &&
                        ((mode_q == SHM_ARITH) ? bus.sr_out[WIDTH-1] : (rot && bus.sr_out[0]));
    assign bus.sr_in  = sr_in_q;
    assign bus.sr_c1  = sel_q[1];
    assign bus.sr_c0  = sel_q[0];
    assign bus.sr_enb = enb_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    // The register holds during DONE, so its contents are the result in that cycle
    assign bus.result = (state_q == DONE) ? bus.sr_out : result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench driving the sequencer and a real shift register
module tb_shift_sequencer;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   saw_done;

    always #5 clk = ~clk;

`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic [7:0] ROL_EXP = 8'h03;
    localparam logic [7:0] ROR_EXP = 8'hC0;
`else
    localparam logic [7:0] ROL_EXP = 8'h02;
    localparam logic [7:0] ROR_EXP = 8'h40;
`endif

    shift_sequencer_if bus();

    shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    eight_bit_UniversalShiftRegister u_sr (
        .clk (clk),
        .enb (bus.sr_enb),
        .c1  (bus.sr_c1),
        .c0  (bus.sr_c0),
        .sli (bus.sr_sli),
        .sri (bus.sr_sri),
        .pin (bus.sr_in),
        .q   (bus.sr_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] res);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " done"}, bus.done, 0);
        chk({tag, " result"}, bus.result, res);
        chk({tag, " ctrl"}, {bus.sr_c1, bus.sr_c0, bus.sr_enb}, 3'b000);
        chk({tag, " state"}, dut.state_q, IDLE);
    endtask

    // Issue one command; poke holds start high while busy to show it is ignored
    task automatic run(input string tag, input logic [7:0] d, input logic [2:0] a,
                       input logic dr, input logic [1:0] m, input logic [7:0] exp, input bit poke);
        int n;
        bus.din = d; bus.amt = a; bus.dir = dr; bus.mode = m; bus.start = 1'b1;
        @(negedge clk);
        bus.start = poke;
        bus.din = ~d;
        chk({tag, " busy load"}, bus.busy, 1);
        chk({tag, " load ctrl"}, {bus.sr_c1, bus.sr_c0, bus.sr_enb}, 3'b111);
        chk({tag, " sr_in"}, bus.sr_in, d);
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 2 && a != 3'd0)
                chk({tag, " shift ctrl"}, {bus.sr_c1, bus.sr_c0, bus.sr_enb}, dr ? 3'b011 : 3'b101);
        end
        bus.start = 1'b0;
        chk({tag, " done cycle"}, n, a + 2);
        chk({tag, " result"}, bus.result, exp);
        chk({tag, " busy done"}, bus.busy, 1);
        @(negedge clk);
        check_idle_outputs({tag, " after"}, exp);
    endtask

    initial begin
        bus.start = 1'b0; bus.din = '0; bus.amt = '0; bus.dir = 1'b0; bus.mode = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst", 8'h00);
        chk("rst sli/sri", {bus.sr_sli, bus.sr_sri}, 2'b00);
        chk("rst sr_in", bus.sr_in, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rel", 8'h00);

        run("lsl3", 8'hB5, 3'd3, 1'b0, 2'b00, 8'hA8, 1'b0);
        run("asr2", 8'h96, 3'd2, 1'b1, 2'b01, 8'hE5, 1'b0);
        run("lsr2", 8'h96, 3'd2, 1'b1, 2'b00, 8'h25, 1'b0);
        run("rsvd", 8'h96, 3'd2, 1'b1, 2'b11, 8'h25, 1'b0);
        run("asl2", 8'h96, 3'd2, 1'b0, 2'b01, 8'h58, 1'b0);
        run("rol1", 8'h81, 3'd1, 1'b0, 2'b10, ROL_EXP, 1'b0);
        run("ror1", 8'h81, 3'd1, 1'b1, 2'b10, ROR_EXP, 1'b0);
        run("amt0", 8'h5A, 3'd0, 1'b0, 2'b00, 8'h5A, 1'b1);
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_done |= bus.done | bus.busy;
        end
        chk("no second done", saw_done, 0);
        chk("result held", bus.result, 8'h5A);

        bus.din = 8'hFF; bus.amt = 3'd7; bus.dir = 1'b0; bus.mode = 2'b00; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid state", dut.state_q, SHIFT);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort", 8'h00);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_done |= bus.done;
        end
        chk("abort no done", saw_done, 0);
        run("post", 8'h96, 3'd2, 1'b1, 2'b01, 8'hE5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
